sap1_step_sequencer: RTL
========================

Name: sap1_step_sequencer

Overview:
- Microstep sequencer for the SAP-1 control path. It owns the step counter that feeds the instruction decoder and gates datapath register updates via a clock-enable.
- It consumes the decoder's halt and advance strobes and provides free-run, single-microstep and single-instruction execution modes.
- It also maintains a retired-instruction counter for debug and test.

Parameters:
- INSTRUCTION_STEPS, 8, microsteps per instruction slot. Must be a power of two, at least 4.
- COUNT_WIDTH, 16, width of the retired-instruction counter.
- STEP_WIDTH, $clog2(INSTRUCTION_STEPS), localparam. Width of the step bus.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_run  in  1  level; 1 = free-run, 0 = paused
- i_step_req  in  1  level from debounced button; rising edge requests one step operation
- i_step_instr  in  1  sampled on step request; 0 = one microstep, 1 = run to instruction boundary
- i_halt  in  1  decoder halt strobe for current step
- i_adv  in  1  decoder advance strobe for current step
- o_step  out  STEP_WIDTH  current microstep, drives decoder i_step
- o_clk_en  out  1  datapath registers may update on this edge
- o_halted  out  1  sequencer is in HALTED
- o_instr_done  out  1  one-cycle pulse after an instruction retires
- o_instr_count  out  COUNT_WIDTH  retired instructions, saturating

Behaviour:
- Reset (synchronous, i_reset=1 at edge):
  - state=IDLE, o_step=0, o_instr_count=0, o_instr_done=0.
  - Edge-detector history is cleared to 0.
  - Reset overrides every other input; mid-instruction reset abandons the instruction.
- States: IDLE, RUN, SINGLE, BURST, HALTED. Encoding is registered.
- o_clk_en = (state==RUN | SINGLE | BURST). It is decoded only from the state register, with no combinational path from inputs.
- o_halted = (state==HALTED).
- step_edge = i_step_req & ~prev_step_req. prev_step_req is registered every cycle in every state.
- Enabled edge (o_clk_en=1), in priority order:
  - i_halt=1: state→HALTED, o_step held, no count. i_adv is ignored.
  - else if i_adv=1 or o_step==INSTRUCTION_STEPS-1: o_step→0, instruction retires.
  - else: o_step→o_step+1.
- Retire:
  - o_instr_count increments, saturating at all-ones.
  - o_instr_done=1 for exactly the next cycle, coincident with o_step==0.
- Transitions:
  - IDLE: i_run=1 → RUN. Otherwise, on step_edge with i_step_instr=0 → SINGLE; with i_step_instr=1 → BURST. i_run has priority over step_edge.
  - RUN: halt → HALTED; i_run=0 → IDLE (microstep granularity, o_step preserved); else stay.
  - SINGLE: halt → HALTED; else → IDLE after exactly one enabled cycle.
  - BURST: halt → HALTED; retire → IDLE; else stay. BURST ignores i_run until it returns to IDLE.
  - HALTED: terminal until i_reset. o_clk_en=0, o_step frozen.
- Step requests in RUN/SINGLE/BURST/HALTED are discarded, not queued.
- Latency: an i_run rise or step_edge sampled at edge N gives o_clk_en=1 in cycle N+1.
- Wrap: o_step never exceeds INSTRUCTION_STEPS-1. The retire at max step occurs even without i_adv.

Decomposition:
- Shared header sap1_defs.vh holds:
  - state encodings (ST_IDLE, ST_RUN, ST_SINGLE, ST_BURST, ST_HALTED, 3 bits);
  - the INSTRUCTION_STEPS default;
  - the STEP_WIDTH derivation, also used by the decoder and top level.
- One sub-module, rising_edge_detect: 1-bit, synchronous reset, output = in & ~prev. Used for i_step_req.

Test Plan:
- Reset, i_run=1; decoder asserts i_adv at step 4 (LDA-like) → o_step sequence 0,1,2,3,4,0; o_instr_done high the cycle o_step returns to 0; o_instr_count=1.
- i_run=0, i_step_instr=0, three i_step_req pulses → o_clk_en high for exactly 3 isolated cycles; o_step=3; o_instr_count=0.
- i_run=0, i_step_instr=1, one pulse, adv at step 3 → o_clk_en high 4 consecutive cycles; state back to IDLE with o_step=0 and o_instr_count=1.
- i_halt=1 at step 2 while running → o_halted=1 next cycle; o_step stays 2; o_clk_en=0. Further i_run and step pulses for 20 cycles have no effect. i_reset → o_step=0, o_halted=0.
- No i_adv ever, INSTRUCTION_STEPS=8, run 16 cycles → o_step wraps 7→0 twice; o_instr_count=2.
- Count saturation with COUNT_WIDTH=4: run 20 instructions → o_instr_count holds 15. Also check i_reset asserted mid-BURST at step 2 → next cycle IDLE, o_step=0, o_instr_done=0.

Source files
------------

// File: rtl/sap1_step_sequencer_pkg.sv
// ============================================================================
// Module      : sap1_step_sequencer_pkg
// Description : State encodings and step-bus sizing shared by the SAP-1
//               sequencer, decoder and top level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sap1_step_sequencer_pkg;

    localparam int INSTRUCTION_STEPS_DEFAULT = 8;
    localparam int STATE_WIDTH               = 3;

    localparam logic [STATE_WIDTH-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_WIDTH-1:0] ST_RUN    = 3'd1;
    localparam logic [STATE_WIDTH-1:0] ST_SINGLE = 3'd2;
    localparam logic [STATE_WIDTH-1:0] ST_BURST  = 3'd3;
    localparam logic [STATE_WIDTH-1:0] ST_HALTED = 3'd4;

    function automatic int step_width(input int steps);
        return $clog2(steps);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sap1_step_sequencer_rising_edge_detect.sv
// ============================================================================
// Module      : rising_edge_detect
// Description : One-bit rising-edge detector; output = in & ~previous in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rising_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_in,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_in;
        end
    end

    assign o_rise = i_in & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/sap1_step_sequencer.sv
// ============================================================================
// Module      : sap1_step_sequencer
// Description : SAP-1 microstep sequencer with free-run, single-step and
//               single-instruction modes plus a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sap1_step_sequencer
    import sap1_step_sequencer_pkg::*;
#(
    parameter  int INSTRUCTION_STEPS = INSTRUCTION_STEPS_DEFAULT,
    parameter  int COUNT_WIDTH       = 16,
    localparam int STEP_WIDTH        = step_width(INSTRUCTION_STEPS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_run,
    input  logic                   i_step_req,
    input  logic                   i_step_instr,
    input  logic                   i_halt,
    input  logic                   i_adv,
    output logic [STEP_WIDTH-1:0]  o_step,
    output logic                   o_clk_en,
    output logic                   o_halted,
    output logic                   o_instr_done,
    output logic [COUNT_WIDTH-1:0] o_instr_count
);

    localparam logic [STEP_WIDTH-1:0] c_STEP_MAX = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    logic [STATE_WIDTH-1:0] r_state;
    logic [STATE_WIDTH-1:0] w_state_next;
    logic [STEP_WIDTH-1:0]  r_step;
    logic [STEP_WIDTH-1:0]  w_step_next;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_instr_done;
    logic                   w_retire;
    logic                   w_enabled;
    logic                   w_halted;
    logic                   w_step_edge;

    rising_edge_detect u_step_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_in    (i_step_req),
        .o_rise  (w_step_edge)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_step       <= '0;
            r_count      <= '0;
            r_instr_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_step       <= w_step_next;
            r_instr_done <= w_retire;
            if (w_retire && (r_count != {COUNT_WIDTH{1'b1}})) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
        end
    end

    // Halt wins over advance; the last microstep retires even without i_adv.
    always_comb begin
        w_retire     = 1'b0;
        w_step_next  = r_step;
        w_state_next = r_state;
        if (w_enabled && !i_halt) begin
            if (i_adv || (r_step == c_STEP_MAX)) begin
                w_retire    = 1'b1;
                w_step_next = '0;
            end else begin
                w_step_next = r_step + STEP_WIDTH'(1);
            end
        end
        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_state_next = ST_RUN;
                end else if (w_step_edge) begin
                    w_state_next = i_step_instr ? ST_BURST : ST_SINGLE;
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    w_state_next = ST_HALTED;
                end else if (!i_run) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SINGLE: begin
                w_state_next = i_halt ? ST_HALTED : ST_IDLE;
            end
            ST_BURST: begin
                if (i_halt) begin
                    w_state_next = ST_HALTED;
                end else if (w_retire) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_enabled = (r_state == ST_RUN) || (r_state == ST_SINGLE) || (r_state == ST_BURST);
        w_halted  = (r_state == ST_HALTED);
    end

    assign o_step        = r_step;
    assign o_clk_en      = w_enabled;
    assign o_halted      = w_halted;
    assign o_instr_done  = r_instr_done;
    assign o_instr_count = r_count;

endmodule

`default_nettype wire
